// File: rtl/module_bcd_secuencial.sv
// Sequential signed binary-to-BCD converter (double dabble, one bit per clock).
// The magnitude of the two's-complement input is converted into a five-digit BCD
// accumulator. The four displayed digits, sign and overflow are registered and
// change only when a conversion finishes, so the display never sees partial digits.
module module_bcd_secuencial #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] numero_input,
  output logic [3:0]       unidades_output,
  output logic [3:0]       decenas_output,
  output logic [3:0]       centenas_output,
  output logic [3:0]       millares_output,
  output logic             signo,
  output logic             overflow,
  output logic             busy,
  output logic             listo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [19:0]      bcd_q, bcd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             lost_q, lost_d;     // a set bit fell off the top of the accumulator
  logic             sign_int_q, sign_int_d;
  logic [15:0]      digits_q, digits_d;
  logic             signo_q, signo_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             listo_q, listo_d;

  logic [19:0]      bcd_adj;
  logic [CntW-1:0]  cnt_inc;
  logic             ovf_now;

  // Add-3 correction: every nibble >= 5 is bumped before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign cnt_inc = cnt_q + CntW'(1);

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    lost_d     = lost_q;
    sign_int_d = sign_int_q;
    digits_d   = digits_q;
    signo_d    = signo_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    listo_d    = 1'b0;
    ovf_now    = lost_q | (bcd_q[19:16] != 4'd0);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_int_d = numero_input[WIDTH-1];
          // Most negative value maps to its true magnitude as an unsigned word.
          mag_d      = numero_input[WIDTH-1] ?
                       (~numero_input + {{(WIDTH-1){1'b0}}, 1'b1}) : numero_input;
          bcd_d      = '0;
          cnt_d      = '0;
          lost_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        {bcd_d, mag_d} = {bcd_adj[18:0], mag_q, 1'b0};
        lost_d         = lost_q | bcd_adj[19];
        cnt_d          = cnt_inc;
        if (cnt_inc == CntW'(WIDTH)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        ovf_d    = ovf_now;
        digits_d = (ovf_now && SATURATE) ? 16'h9999 : bcd_q[15:0];
        signo_d  = sign_int_q;
        busy_d   = 1'b0;
        listo_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      lost_q     <= 1'b0;
      sign_int_q <= 1'b0;
      digits_q   <= '0;
      signo_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      lost_q     <= lost_d;
      sign_int_q <= sign_int_d;
      digits_q   <= digits_d;
      signo_q    <= signo_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      listo_q    <= listo_d;
    end
  end

  assign millares_output = digits_q[15:12];
  assign centenas_output = digits_q[11:8];
  assign decenas_output  = digits_q[7:4];
  assign unidades_output = digits_q[3:0];
  assign signo           = signo_q;
  assign overflow        = ovf_q;
  assign busy            = busy_q;
  assign listo           = listo_q;

endmodule

// File: tb/tb_module_bcd_secuencial.sv
// Directed bench for module_bcd_secuencial: a saturating and a non-saturating
// instance share the stimulus; results are compared against hand-computed tables.
module tb_module_bcd_secuencial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] numero_input;

  logic [3:0] u1, d1, c1, m1, u2, d2, c2, m2;
  logic       sg1, ov1, busy1, listo1, sg2, ov2, busy2, listo2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  module_bcd_secuencial #(.WIDTH(16), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .numero_input(numero_input),
    .unidades_output(u1), .decenas_output(d1), .centenas_output(c1),
    .millares_output(m1), .signo(sg1), .overflow(ov1), .busy(busy1), .listo(listo1)
  );

  module_bcd_secuencial #(.WIDTH(16), .SATURATE(1'b0)) dut_nsat (
    .clk(clk), .rst(rst), .start(start), .numero_input(numero_input),
    .unidades_output(u2), .decenas_output(d2), .centenas_output(c2),
    .millares_output(m2), .signo(sg2), .overflow(ov2), .busy(busy2), .listo(listo2)
  );

  typedef struct {
    logic [15:0] val;
    logic [15:0] dig_sat;   // expected digits, thousands..units, SATURATE=1
    logic [15:0] dig_nsat;  // expected digits, SATURATE=0
    logic        sg;
    logic        ov;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where listo is seen (or budget expiry).
  // lat = posedges after the sampling edge; bcnt = cycles with busy high.
  task automatic convert(input logic [15:0] v, output int lat, output int bcnt);
    start        = 1'b1;
    numero_input = v;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!listo1 && lat < 40) begin
      if (busy1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t e);
    check({tag, " digits"},      {16'h0, m1, c1, d1, u1}, {16'h0, e.dig_sat});
    check({tag, " signo"},       {31'h0, sg1}, {31'h0, e.sg});
    check({tag, " overflow"},    {31'h0, ov1}, {31'h0, e.ov});
    check({tag, " nsat digits"}, {16'h0, m2, c2, d2, u2}, {16'h0, e.dig_nsat});
    check({tag, " nsat ovf"},    {31'h0, ov2}, {31'h0, e.ov});
    check({tag, " nsat listo"},  {31'h0, listo2}, 32'd1);
  endtask

  initial begin
    int   lat, bcnt, seen;
    vec_t e;

    vecs[0]  = '{16'd42,    16'h0042, 16'h0042, 1'b0, 1'b0};
    vecs[1]  = '{16'hC080,  16'h9999, 16'h6256, 1'b1, 1'b1};
    vecs[2]  = '{16'd9999,  16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[3]  = '{16'd10000, 16'h9999, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000,  16'h9999, 16'h2768, 1'b1, 1'b1};
    vecs[5]  = '{16'd0,     16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{16'd1,     16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{16'hFFFF,  16'h0001, 16'h0001, 1'b1, 1'b0};
    vecs[8]  = '{16'd127,   16'h0127, 16'h0127, 1'b0, 1'b0};
    vecs[9]  = '{16'hFF80,  16'h0128, 16'h0128, 1'b1, 1'b0};
    vecs[10] = '{16'd0,     16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{16'hF9F7,  16'h1545, 16'h1545, 1'b1, 1'b0};  // -1545

    rst          = 1'b1;
    start        = 1'b0;
    numero_input = '0;
    #1;
    check("reset digits", {16'h0, m1, c1, d1, u1}, 32'h0);
    check("reset flags", {28'h0, sg1, ov1, busy1, listo1}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back table; each call starts right in the previous listo cycle.
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].val, lat, bcnt);
      check($sformatf("vec%0d latency", i), lat, 17);
      check($sformatf("vec%0d busy cycles", i), bcnt, 17);
      check_result($sformatf("vec%0d", i), vecs[i]);
    end
    @(negedge clk);
    check("listo one cycle", {31'h0, listo1}, 32'd0);

    // Second start at cycle 8 of a conversion is ignored.
    start        = 1'b1;
    numero_input = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!listo1 && lat < 40) begin
      if (lat == 7) begin
        start        = 1'b1;
        numero_input = 16'd5678;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("ignore latency", lat, 17);
    e = '{16'd1234, 16'h1234, 16'h1234, 1'b0, 1'b0};
    check_result("ignore", e);

    // Start accepted in the listo cycle.
    convert(16'd5678, lat, bcnt);
    check("listo-cycle latency", lat, 17);
    e = '{16'd5678, 16'h5678, 16'h5678, 1'b0, 1'b0};
    check_result("listo-cycle", e);
    @(negedge clk);

    // Reset mid-conversion: outputs clear at once, no listo follows.
    start        = 1'b1;
    numero_input = 16'hFFB3;  // -77
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort digits", {16'h0, m1, c1, d1, u1}, 32'h0);
    check("abort flags", {28'h0, sg1, ov1, busy1, listo1}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (listo1 || busy1) seen++;
    end
    check("abort no listo", seen, 0);

    convert(16'hFFB3, lat, bcnt);
    check("after-abort latency", lat, 17);
    e = '{16'hFFB3, 16'h0077, 16'h0077, 1'b1, 1'b0};
    check_result("after-abort", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
